// File: rtl/usb_turnaround_ctrl.sv
// usb_turnaround_ctrl: bus-turnaround sequencer between the SIE TX and RX paths.
// After a TX packet that expects a response, it waits a bounded number of bit
// times for the response to start. After any RX EOP, it holds off TX for the
// minimum inter-packet gap.
// One bit time is 4 cycles of clk48_i.
// Optional build macro: USB_TURNAROUND_STATS_EN adds a saturating timeout counter.
module usb_turnaround_ctrl #(
  parameter int TIMEOUT_BITS = 16,
  parameter int MIN_GAP_BITS = 2
) (
  input  logic       clk48_i,
  input  logic       rst_i,
  input  logic       txEop_i,
  input  logic       expectResp_i,
  input  logic       rxGotSignal_i,
  input  logic       rxEop_i,
  input  logic       abort_i,
  output logic       waitingResp_o,
  output logic       respStart_o,
  output logic       respDone_o,
  output logic       timeout_o,
  output logic       txGapOk_o,
  output logic [7:0] timeoutCnt_o
);

  localparam int MAX_BITS = (TIMEOUT_BITS > MIN_GAP_BITS) ? TIMEOUT_BITS : MIN_GAP_BITS;
  localparam int CNT_WID  = $clog2(MAX_BITS + 1);

  // A window ends on the bit tick that carries bit_cnt up to its limit.
  // The state change therefore lands exactly 4*N cycles after entry.
  localparam logic [CNT_WID-1:0] TO_LAST  = CNT_WID'(TIMEOUT_BITS - 1);
  localparam logic [CNT_WID-1:0] GAP_LAST = CNT_WID'(MIN_GAP_BITS - 1);
  localparam logic [CNT_WID-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RX   = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t               state, state_nx;
  logic [1:0]           presc;
  logic [CNT_WID-1:0]   bit_cnt;
  logic                 restart;
  logic                 start_nx, done_nx, to_nx;
  logic                 start_q, done_q, to_q;
  logic                 bit_tick, to_hit, gap_hit;

  assign bit_tick = (presc == 2'd3);
  assign to_hit   = bit_tick && (bit_cnt == TO_LAST);
  assign gap_hit  = bit_tick && (bit_cnt == GAP_LAST);

  // Next-state and pulse decode; abort overrides every other event.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    start_nx = 1'b0;
    done_nx  = 1'b0;
    to_nx    = 1'b0;
    if (abort_i) begin
      state_nx = S_IDLE;
      restart  = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (txEop_i) begin
            state_nx = expectResp_i ? S_WAIT : S_IDLE;
            restart  = 1'b1;
          end else if (rxEop_i) begin
            state_nx = S_GAP;
            restart  = 1'b1;
          end
        end
        S_WAIT: begin
          // A response seen on the expiry cycle still counts as a response.
          if (rxGotSignal_i) begin
            state_nx = S_RX;
            start_nx = 1'b1;
            restart  = 1'b1;
          end else if (to_hit) begin
            state_nx = S_IDLE;
            to_nx    = 1'b1;
            restart  = 1'b1;
          end
        end
        S_RX: begin
          if (rxEop_i) begin
            state_nx = S_GAP;
            done_nx  = 1'b1;
            restart  = 1'b1;
          end
        end
        S_GAP: begin
          if (rxEop_i) begin
            restart = 1'b1;
          end else if (gap_hit) begin
            state_nx = S_IDLE;
            restart  = 1'b1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          restart  = 1'b1;
        end
      endcase
    end
  end

  // State register and one-cycle response/timeout pulses.
  always_ff @(posedge clk48_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_IDLE;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= start_nx;
      done_q  <= done_nx;
      to_q    <= to_nx;
    end
  end

  // Bit-time base: the prescaler and bit counter restart on every state entry.
  always_ff @(posedge clk48_i or posedge rst_i) begin
    if (rst_i) begin
      presc   <= 2'd0;
      bit_cnt <= '0;
    end else if (restart) begin
      presc   <= 2'd0;
      bit_cnt <= '0;
    end else begin
      presc <= presc + 2'd1;
      if (bit_tick && (bit_cnt != CNT_MAX)) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign waitingResp_o = (state == S_WAIT);
  assign txGapOk_o     = (state == S_IDLE);
  assign respStart_o   = start_q;
  assign respDone_o    = done_q;
  assign timeout_o     = to_q;

`ifdef USB_TURNAROUND_STATS_EN
  logic [7:0] to_cnt;

  // Saturating count of timeouts; only reset clears it.
  always_ff @(posedge clk48_i or posedge rst_i) begin
    if (rst_i)                         to_cnt <= 8'd0;
    else if (to_nx && to_cnt != 8'hFF) to_cnt <= to_cnt + 8'd1;
  end

  assign timeoutCnt_o = to_cnt;
`else
  assign timeoutCnt_o = 8'd0;
`endif

endmodule
